// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised FIFO.
// fifo_status_t mirrors the flag outputs so scoreboards can compare them as one word.
package fifo_pkg;

  localparam int MIN_DEPTH = 4;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read port.
// With BYPASS set, a write to the address being loaded is forwarded into the read register.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The array is read asynchronously; forwarding covers a write landing on the head slot.
  assign rdata = (BYPASS && we && (waddr == raddr)) ? wdata : mem[raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (re) q <= rdata;
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds, occupancy count,
// overflow/underflow pulses and selectable first-word-fall-through read mode.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  parameter bit FWFT   = 1'b0,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);

  if (!is_pow2(DEPTH) || DEPTH < MIN_DEPTH) begin : g_bad_depth
    $error("fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (AE_LVL >= AF_LVL) begin : g_bad_levels
    $error("fifo_param: AE_LVL must be below AF_LVL");
  end

  localparam logic [AW:0] AF_C    = (AW + 1)'(AF_LVL);
  localparam logic [AW:0] AE_C    = (AW + 1)'(AE_LVL);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  // Handshake: wr/rd are requests sampled every rising edge. A read is taken when the FIFO
  // holds data; a write is taken when not full, or when full and a read is taken the same
  // edge. Rejected requests raise overflow/underflow for one cycle and change nothing else.
  logic [AW:0]  wr_ptr, rd_ptr, rd_ptr_nxt, count_nxt;
  logic         ra, wa;
  logic         mem_re;
  logic [AW-1:0] mem_raddr;
  fifo_status_t st;

  assign ra         = rd & ~st.empty;
  assign wa         = wr & (~st.full | ra);
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, ra};
  assign count_nxt  = count + {{AW{1'b0}}, wa} - {{AW{1'b0}}, ra};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      st     <= '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1, almost_full: 1'b0,
                  overflow: 1'b0, underflow: 1'b0};
    end else begin
      wr_ptr          <= wr_ptr + {{AW{1'b0}}, wa};
      rd_ptr          <= rd_ptr_nxt;
      count           <= count_nxt;
      st.empty        <= (count_nxt == '0);
      st.full         <= (count_nxt == DEPTH_C);
      st.almost_empty <= (count_nxt <= AE_C);
      st.almost_full  <= (count_nxt >= AF_C);
      st.overflow     <= wr & ~wa;
      st.underflow    <= rd & ~ra;
    end
  end

  // FWFT keeps the read register loaded with whatever word will be at the head after this edge.
  assign mem_re    = FWFT ? (count_nxt != '0) : ra;
  assign mem_raddr = FWFT ? rd_ptr_nxt[AW-1:0] : rd_ptr[AW-1:0];

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW),
    .BYPASS (FWFT)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst),
    .we    (wa),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .re    (mem_re),
    .raddr (mem_raddr),
    .q     (dout)
  );

  assign empty        = st.empty;
  assign full         = st.full;
  assign almost_empty = st.almost_empty;
  assign almost_full  = st.almost_full;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;

endmodule
